// File: rtl/iob_target_if.sv
// IOB target bus bundle: 68000-side strobes/acks plus the local REQ/RDY/ERR handshake.
// The slave modport is the target's view; the master modport is the IOB/local side.
interface iob_target_if;
  logic        E;
  logic [23:1] A;
  logic        nAS;
  logic        RnW;
  logic        nUDS;
  logic        nLDS;
  logic        nVMA;
  logic        nDTACK;
  logic        nVPA;
  logic        nBERR;
  logic        nDOE;
  logic        REQ;
  logic        WR;
  logic [1:0]  BE;
  logic [19:1] ADDR;
  logic        RDY;
  logic        ERR;

  modport slave (
    input  E, A, nAS, RnW, nUDS, nLDS, nVMA, RDY, ERR,
    output nDTACK, nVPA, nBERR, nDOE, REQ, WR, BE, ADDR
  );

  modport master (
    output E, A, nAS, RnW, nUDS, nLDS, nVMA, RDY, ERR,
    input  nDTACK, nVPA, nBERR, nDOE, REQ, WR, BE, ADDR
  );
endinterface

// File: rtl/iob_target.sv
// MC68000-bus target on the IOB: decodes nAS/strobes/address, issues a local request and
// answers with nDTACK (async), nVPA (E-synchronous) or nBERR. Outputs are active-low levels.
module iob_target #(
  parameter logic [3:0] BASE  = 4'hE,
  parameter bit         ESYNC = 1'b1,
  parameter int         WS    = 2,
  parameter int         TMO   = 255
) (
  input  logic          C16M,
  input  logic          RES,
  iob_target_if.slave   bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACK, S_VPA, S_VREQ, S_VWAIT, S_VHOLD, S_BERR
  } state_t;

  localparam logic [7:0] WS_C  = WS[7:0];
  localparam logic [7:0] TMO_C = TMO[7:0];

  state_t      state_reg, state_next;
  logic        as_s1_reg, as_s2_reg;
  logic        e_s1_reg, e_s2_reg;
  logic        vma_reg;
  logic [7:0]  cnt_reg, cnt_next;
  logic        rdy_seen_reg, rdy_seen_next;
  logic        wr_reg;
  logic [1:0]  be_reg;
  logic [19:1] addr_reg;
  logic        capture;

  logic       as_on, as_off, e_fall, strobe, hit, rdy_now;
  logic [7:0] cnt_inc;

  assign as_on   = !as_s1_reg && !as_s2_reg;
  assign as_off  = as_s1_reg && as_s2_reg;
  assign e_fall  = e_s2_reg && !e_s1_reg;
  assign strobe  = !bus.nUDS || !bus.nLDS;
  assign hit     = as_on && strobe && (bus.A[23:20] == BASE);
  assign rdy_now = rdy_seen_reg || bus.RDY;
  assign cnt_inc = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

  always_ff @(posedge C16M) begin
    if (RES) begin
      state_reg    <= S_IDLE;
      as_s1_reg    <= 1'b1;
      as_s2_reg    <= 1'b1;
      e_s1_reg     <= 1'b0;
      e_s2_reg     <= 1'b0;
      vma_reg      <= 1'b1;
      cnt_reg      <= 8'd0;
      rdy_seen_reg <= 1'b0;
      wr_reg       <= 1'b0;
      be_reg       <= 2'b00;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      as_s1_reg    <= bus.nAS;
      as_s2_reg    <= as_s1_reg;
      e_s1_reg     <= bus.E;
      e_s2_reg     <= e_s1_reg;
      vma_reg      <= bus.nVMA;
      cnt_reg      <= cnt_next;
      rdy_seen_reg <= rdy_seen_next;
      if (capture) begin
        wr_reg   <= !bus.RnW;
        be_reg   <= {!bus.nUDS, !bus.nLDS};
        addr_reg <= bus.A[19:1];
      end
    end
  end

  // cnt_next is the number of cycles elapsed since REQ rose, as seen after this edge,
  // so a RDY in the cycle after REQ yields nDTACK exactly WS cycles after REQ.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rdy_seen_next = rdy_seen_reg;
    capture       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (hit) begin
          capture    = 1'b1;
          cnt_next   = 8'd0;
          state_next = (ESYNC && bus.A[19]) ? S_VPA : S_REQ;
        end
      end
      S_REQ: begin
        cnt_next      = 8'd1;
        rdy_seen_next = 1'b0;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        cnt_next      = cnt_inc;
        rdy_seen_next = rdy_now;
        if (bus.ERR)                          state_next = S_BERR;
        else if (rdy_now && cnt_inc >= WS_C)  state_next = S_ACK;
        else if (cnt_inc == TMO_C)            state_next = S_BERR;
        else if (as_off)                      state_next = S_IDLE;
      end
      S_ACK: begin
        // TAS/RMW phase boundary: strobes drop while nAS is still held (raw and synced),
        // which keeps a normal end-of-cycle (nAS and strobes rising together) out of it.
        if (as_off)
          state_next = S_IDLE;
        else if (as_on && !bus.nAS && bus.nUDS && bus.nLDS)
          state_next = S_IDLE;
      end
      S_VPA: begin
        if (as_off)        state_next = S_IDLE;
        else if (!vma_reg) state_next = S_VREQ;
      end
      S_VREQ: begin
        cnt_next      = 8'd0;
        rdy_seen_next = 1'b0;
        state_next    = S_VWAIT;
      end
      S_VWAIT: begin
        rdy_seen_next = rdy_now;
        if (bus.ERR)     state_next = S_BERR;
        else if (e_fall) state_next = rdy_now ? S_VHOLD : S_BERR;
      end
      S_VHOLD: if (as_off) state_next = S_IDLE;
      S_BERR:  if (as_off) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.REQ    = (state_reg == S_REQ) || (state_reg == S_VREQ);
    bus.nDTACK = !(state_reg == S_ACK);
    bus.nBERR  = !(state_reg == S_BERR);
    bus.nVPA   = !((state_reg == S_VPA) || (state_reg == S_VREQ) ||
                   (state_reg == S_VWAIT) || (state_reg == S_VHOLD));
    bus.nDOE   = !(!wr_reg && (state_reg != S_IDLE) && (state_reg != S_VPA));
  end

  assign bus.WR   = wr_reg;
  assign bus.BE   = be_reg;
  assign bus.ADDR = addr_reg;
endmodule

// File: tb/tb_iob_target.sv
// Directed bench for iob_target: async write/read, timeout, E-sync, decode misses,
// reset mid-cycle, TAS and local error, each checked against hand-derived values.
module tb_iob_target;
  logic C16M = 1'b0;
  logic RES  = 1'b1;
  iob_target_if bus ();

  iob_target #(.BASE(4'hE), .ESYNC(1'b1), .WS(2), .TMO(255)) dut (
    .C16M(C16M),
    .RES (RES),
    .bus (bus)
  );

  always #5 C16M = ~C16M;

  int passes = 0, checks = 0;
  int req_cnt = 0, dtack_pulses = 0, excl_viol = 0;
  logic dtack_prev = 1'b1;

  always @(negedge C16M) begin
    if (bus.REQ === 1'b1) req_cnt++;
    if (bus.nDTACK === 1'b0 && dtack_prev === 1'b1) dtack_pulses++;
    dtack_prev = bus.nDTACK;
    if (int'(bus.nDTACK === 1'b0) + int'(bus.nVPA === 1'b0) + int'(bus.nBERR === 1'b0) > 1)
      excl_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge C16M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.REQ !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, {31'd0, bus.REQ}, 32'd1);
  endtask

  task automatic wait_vpa(input string tag);
    int n = 0;
    while (bus.nVPA !== 1'b0 && n < 16) begin
      step();
      n++;
    end
    chk({tag, "_vpa_low"}, {31'd0, bus.nVPA}, 32'd0);
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic rnw,
                             input logic uds, input logic lds);
    bus.A    = addr[23:1];
    bus.RnW  = rnw;
    bus.nUDS = ~uds;
    bus.nLDS = ~lds;
    bus.nAS  = 1'b0;
  endtask

  task automatic end_cycle();
    bus.nAS  = 1'b1;
    bus.nUDS = 1'b1;
    bus.nLDS = 1'b1;
    bus.nVMA = 1'b1;
    step(3);
  endtask

  task automatic rdy_pulse();
    bus.RDY = 1'b1;
    step();
    bus.RDY = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {27'd0, bus.nDTACK, bus.nVPA, bus.nBERR, bus.nDOE, bus.REQ}, 32'b11110);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {5'd0, bus.nDTACK, bus.nVPA, bus.nBERR, bus.nDOE, bus.REQ, bus.WR, bus.BE, bus.ADDR},
        {5'd0, 5'b11110, 1'b0, 2'b00, 19'd0});
  endtask

  initial begin
    int r0, d0, bad;
    bus.E = 1'b0; bus.A = '0; bus.nAS = 1'b1; bus.RnW = 1'b1;
    bus.nUDS = 1'b1; bus.nLDS = 1'b1; bus.nVMA = 1'b1; bus.RDY = 1'b0; bus.ERR = 1'b0;
    step(2);
    chk_reset("reset");
    RES = 1'b0;
    step(3);

    // 1: word write, RDY in the cycle after REQ
    r0 = req_cnt;
    start_cycle(24'hE00010, 1'b0, 1'b1, 1'b1);
    wait_req("t1");
    chk("t1_wr", {31'd0, bus.WR}, 32'd1);
    chk("t1_be", {30'd0, bus.BE}, 32'd3);
    chk("t1_addr", {13'd0, bus.ADDR}, 32'h8);
    chk("t1_ndoe", {31'd0, bus.nDOE}, 32'd1);
    step();
    chk("t1_req_one_cycle", {31'd0, bus.REQ}, 32'd0);
    chk("t1_dtack_req1", {31'd0, bus.nDTACK}, 32'd1);
    rdy_pulse();
    chk("t1_dtack_req2", {31'd0, bus.nDTACK}, 32'd0);
    bus.nAS = 1'b1; bus.nUDS = 1'b1; bus.nLDS = 1'b1;
    step(2);
    chk("t1_dtack_held", {31'd0, bus.nDTACK}, 32'd0);
    step();
    chk("t1_dtack_release", {31'd0, bus.nDTACK}, 32'd1);
    chk("t1_req_count", req_cnt - r0, 32'd1);

    // 2: byte read, no RDY -> bus error after TMO
    r0 = req_cnt;
    start_cycle(24'hE00021, 1'b1, 1'b0, 1'b1);
    wait_req("t2");
    chk("t2_be", {30'd0, bus.BE}, 32'd1);
    chk("t2_wr", {31'd0, bus.WR}, 32'd0);
    chk("t2_addr", {13'd0, bus.ADDR}, 32'h10);
    chk("t2_ndoe", {31'd0, bus.nDOE}, 32'd0);
    bad = 0;
    for (int i = 1; i <= 254; i++) begin
      step();
      if (bus.nBERR !== 1'b1 || bus.nDTACK !== 1'b1) bad++;
    end
    chk("t2_no_early_berr", bad, 32'd0);
    step();
    chk("t2_berr", {29'd0, bus.nBERR, bus.nDTACK, bus.nDOE}, 32'b010);
    end_cycle();
    chk_idle("t2_idle");
    chk("t2_req_count", req_cnt - r0, 32'd1);

    // 3a: E-sync read with RDY before E falls
    r0 = req_cnt;
    start_cycle(24'hE80000, 1'b1, 1'b1, 1'b1);
    wait_vpa("t3a");
    chk("t3a_no_req_before_vma", req_cnt - r0, 32'd0);
    bus.nVMA = 1'b0;
    wait_req("t3a");
    chk("t3a_vreq", {30'd0, bus.nVPA, bus.nDOE}, 32'b00);
    step();
    rdy_pulse();
    bus.E = 1'b1;
    step(3);
    bus.E = 1'b0;
    step(2);
    chk("t3a_vhold", {30'd0, bus.nVPA, bus.nBERR}, 32'b01);
    step(4);
    chk("t3a_vpa_held", {31'd0, bus.nVPA}, 32'd0);
    end_cycle();
    chk_idle("t3a_idle");

    // 3b: E-sync read without RDY -> nBERR on E fall, nVPA handed off
    start_cycle(24'hE80000, 1'b1, 1'b1, 1'b1);
    wait_vpa("t3b");
    bus.nVMA = 1'b0;
    wait_req("t3b");
    step();
    bus.E = 1'b1;
    step(3);
    bus.E = 1'b0;
    step();
    chk("t3b_before_fall", {30'd0, bus.nVPA, bus.nBERR}, 32'b01);
    step();
    chk("t3b_berr", {30'd0, bus.nVPA, bus.nBERR}, 32'b10);
    end_cycle();
    chk_idle("t3b_idle");
    chk("t3_req_count", req_cnt - r0, 32'd2);

    // 4: address miss, then AS without strobes
    r0 = req_cnt;
    start_cycle(24'h400000, 1'b1, 1'b1, 1'b1);
    step(6);
    chk_idle("t4_miss");
    end_cycle();
    start_cycle(24'hE00010, 1'b0, 1'b0, 1'b0);
    step(6);
    chk_idle("t4_nostrobe");
    chk("t4_no_req", req_cnt - r0, 32'd0);
    bus.nUDS = 1'b0; bus.nLDS = 1'b0;
    wait_req("t4_late_strobe");
    step();
    rdy_pulse();
    chk("t4_dtack", {31'd0, bus.nDTACK}, 32'd0);
    end_cycle();

    // 5: reset during WAIT and during ACK, then a normal write
    start_cycle(24'hE00010, 1'b0, 1'b1, 1'b1);
    wait_req("t5w");
    step();
    RES = 1'b1;
    bus.nAS = 1'b1; bus.nUDS = 1'b1; bus.nLDS = 1'b1;
    step();
    chk_reset("t5_reset_wait");
    RES = 1'b0;
    step(3);
    start_cycle(24'hE00010, 1'b0, 1'b1, 1'b1);
    wait_req("t5a");
    step();
    rdy_pulse();
    chk("t5_ack", {31'd0, bus.nDTACK}, 32'd0);
    RES = 1'b1;
    bus.nAS = 1'b1; bus.nUDS = 1'b1; bus.nLDS = 1'b1;
    step();
    chk_reset("t5_reset_ack");
    RES = 1'b0;
    step(3);
    start_cycle(24'hE00040, 1'b0, 1'b1, 1'b1);
    wait_req("t5n");
    chk("t5_addr", {13'd0, bus.ADDR}, 32'h20);
    step();
    rdy_pulse();
    chk("t5_dtack", {31'd0, bus.nDTACK}, 32'd0);
    end_cycle();
    chk_idle("t5_idle");

    // 6: TAS read-modify-write under one nAS
    r0 = req_cnt;
    d0 = dtack_pulses;
    start_cycle(24'hE00010, 1'b1, 1'b1, 1'b0);
    wait_req("t6r");
    chk("t6_read", {28'd0, bus.nDOE, bus.WR, bus.BE}, 32'b0010);
    step();
    rdy_pulse();
    chk("t6_dtack1", {31'd0, bus.nDTACK}, 32'd0);
    bus.nUDS = 1'b1;
    step();
    chk("t6_phase_end", {30'd0, bus.nDTACK, bus.nDOE}, 32'b11);
    bus.RnW = 1'b0;
    bus.nUDS = 1'b0;
    wait_req("t6w");
    chk("t6_write", {31'd0, bus.WR}, 32'd1);
    step();
    rdy_pulse();
    chk("t6_dtack2", {31'd0, bus.nDTACK}, 32'd0);
    end_cycle();
    chk("t6_req_count", req_cnt - r0, 32'd2);
    chk("t6_dtack_pulses", dtack_pulses - d0, 32'd2);

    // 7: local ERR wins over RDY
    start_cycle(24'hE00010, 1'b0, 1'b1, 1'b1);
    wait_req("t7");
    step();
    bus.ERR = 1'b1;
    bus.RDY = 1'b1;
    step();
    bus.ERR = 1'b0;
    bus.RDY = 1'b0;
    chk("t7_berr", {30'd0, bus.nBERR, bus.nDTACK}, 32'b01);
    end_cycle();
    chk_idle("t7_idle");

    chk("exclusive_acks", excl_viol, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
